// File: rtl/cim_accum_pkg.sv
// Shared types and width helpers for the CIM accumulator.
package rho_cim_pkg;

  // Accumulator control states.
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_CIM = 3'd1,
    READ     = 3'd2,
    DRAIN    = 3'd3,
    HANDOFF  = 3'd4
  } accum_state_t;

  // Column address width; never narrower than one bit.
  function automatic int addr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Width that holds the exact sum of v signed cim_w-bit partial sums.
  function automatic int sum_width(input int cim_w, input int v);
    return cim_w + $clog2(v) + 1;
  endfunction

endpackage

// File: rtl/cim_accum_if.sv
// Handshake and data bus between the CIM tiles, the accumulator and the func stage.
interface cim_accum_if
  import rho_cim_pkg::*;
#(
  parameter int xbar_size            = 256,
  parameter int output_size          = 512,
  parameter int v_cim_tiles          = 1,
  parameter int h_cim_tiles          = (output_size + xbar_size - 1) / xbar_size,
  parameter int cim_datatype_size    = 8,
  parameter int output_datatype_size = 16
) ();

  localparam int aw      = addr_width(xbar_size);
  localparam int n_tiles = v_cim_tiles * h_cim_tiles;

  logic                                              i_start;
  logic                                              i_cim_done;
  logic                                              o_cim_re;
  logic [aw-1:0]                                     o_cim_addr;
  logic [n_tiles-1:0][cim_datatype_size-1:0]         i_cim_data;
  logic                                              i_func_busy;
  logic                                              o_start;
  logic                                              o_busy;
  logic [output_size-1:0][output_datatype_size-1:0]  o_data;

  // Environment side: launches passes, supplies tile data, applies backpressure.
  modport master (
    output i_start, i_cim_done, i_cim_data, i_func_busy,
    input  o_cim_re, o_cim_addr, o_start, o_busy, o_data
  );

  // Accumulator side.
  modport slave (
    input  i_start, i_cim_done, i_cim_data, i_func_busy,
    output o_cim_re, o_cim_addr, o_start, o_busy, o_data
  );

endinterface

// File: rtl/cim_accum_sum.sv
// Adds the vertical partial sums of one horizontal tile column and saturates.
module cim_accum_sum
  import rho_cim_pkg::*;
#(
  parameter int cim_w   = 8,
  parameter int v_tiles = 1,
  parameter int out_w   = 16
) (
  input  logic [v_tiles-1:0][cim_w-1:0] data,
  output logic [out_w-1:0]              result
);

  localparam int sw = sum_width(cim_w, v_tiles);

  logic signed [sw-1:0] sum;

  // Sign-extend every partial sum to the full width and add them.
  always_comb begin
    sum = '0;
    for (int v = 0; v < v_tiles; v++) begin
      sum = sum + sw'(signed'(data[v]));
    end
  end

  generate
    if (sw > out_w) begin : g_sat
      localparam logic signed [sw-1:0] sat_max = sw'((64'sd1 <<< (out_w - 1)) - 64'sd1);
      localparam logic signed [sw-1:0] sat_min = ~sat_max;

      // Clamp to the signed output range instead of wrapping.
      always_comb begin
        if (sum > sat_max) begin
          result = sat_max[out_w-1:0];
        end else if (sum < sat_min) begin
          result = sat_min[out_w-1:0];
        end else begin
          result = sum[out_w-1:0];
        end
      end
    end else begin : g_ext
      // Output is wide enough: plain sign extension.
      assign result = out_w'(sum);
    end
  endgenerate

endmodule

// File: rtl/cim_accum.sv
// Reads CIM tile columns after each pass, sums/saturates them into o_data and
// hands the result to the downstream func stage.
module cim_accum
  import rho_cim_pkg::*;
#(
  parameter int xbar_size            = 256,
  parameter int output_size          = 512,
  parameter int v_cim_tiles          = 1,
  parameter int h_cim_tiles          = (output_size + xbar_size - 1) / xbar_size,
  parameter int cim_datatype_size    = 8,
  parameter int output_datatype_size = 16
) (
  input  logic      clk,
  input  logic      rst,
  cim_accum_if.slave bus
);

  localparam int aw        = addr_width(xbar_size);
  localparam int n_tiles   = v_cim_tiles * h_cim_tiles;
  localparam int out_w     = output_datatype_size;
  // With a single horizontal tile only the used columns are read.
  localparam int col_limit = (h_cim_tiles > 1) ? xbar_size : output_size;
  localparam logic [aw-1:0] col_last = aw'(col_limit - 1);

  accum_state_t state_reg;
  logic [aw-1:0] col_reg;
  logic          cim_re_reg;
  logic          busy_reg;
  logic          rd_valid_reg;
  logic [aw-1:0] rd_col_reg;

  logic [n_tiles-1:0][cim_datatype_size-1:0] cim_data;
  logic [h_cim_tiles-1:0][out_w-1:0]         sat_sum;
  logic [output_size-1:0][out_w-1:0]         data_reg;
  logic [output_size-1:0][out_w-1:0]         data_next;

  assign cim_data       = bus.i_cim_data;
  assign bus.o_cim_re   = cim_re_reg;
  assign bus.o_cim_addr = col_reg;
  assign bus.o_busy     = busy_reg;
  assign bus.o_data     = data_reg;
  // Handoff fires in the very cycle the func stage reports idle.
  assign bus.o_start    = (state_reg == HANDOFF) && !bus.i_func_busy;

  // Pass sequencing: launch, column read sweep, drain, handoff.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg  <= IDLE;
      col_reg    <= '0;
      cim_re_reg <= 1'b0;
      busy_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.i_start) begin
            state_reg <= WAIT_CIM;
            busy_reg  <= 1'b1;
          end
        end
        WAIT_CIM: begin
          if (bus.i_cim_done) begin
            state_reg  <= READ;
            col_reg    <= '0;
            cim_re_reg <= 1'b1;
          end
        end
        READ: begin
          if (col_reg == col_last) begin
            state_reg  <= DRAIN;
            col_reg    <= '0;
            cim_re_reg <= 1'b0;
          end else begin
            col_reg <= col_reg + 1'b1;
          end
        end
        DRAIN: begin
          state_reg <= HANDOFF;
        end
        HANDOFF: begin
          if (!bus.i_func_busy) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  // Track which column the tiles are returning this cycle (one-cycle read latency).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_valid_reg <= 1'b0;
      rd_col_reg   <= '0;
    end else begin
      rd_valid_reg <= cim_re_reg;
      rd_col_reg   <= col_reg;
    end
  end

  // One summing/saturating slice per horizontal tile.
  generate
    for (genvar gi = 0; gi < h_cim_tiles; gi++) begin : g_sum
      cim_accum_sum #(
        .cim_w   (cim_datatype_size),
        .v_tiles (v_cim_tiles),
        .out_w   (out_w)
      ) u_sum (
        .data   (cim_data[gi*v_cim_tiles +: v_cim_tiles]),
        .result (sat_sum[gi])
      );
    end
  endgenerate

  // Result element gi comes from tile gi/xbar_size, column gi%xbar_size;
  // columns that map past output_size simply have no element to land in.
  generate
    for (genvar gi = 0; gi < output_size; gi++) begin : g_wr
      localparam logic [aw-1:0] col_of = aw'(gi % xbar_size);
      assign data_next[gi] = (rd_valid_reg && (rd_col_reg == col_of))
                             ? sat_sum[gi / xbar_size] : data_reg[gi];
    end
  endgenerate

  // Result registers; hold their value between captures.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_reg <= '0;
    end else begin
      data_reg <= data_next;
    end
  end

endmodule

// File: tb/tb_cim_accum.sv
// Directed self-checking bench for cim_accum (4x4 crossbar, 6 outputs, 2x2 tiles).
module tb_cim_accum;

  logic clk;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   mode1 = 0;
  int   mode2 = 0;
  logic re1_q, re2_q;
  logic [1:0] addr1_q, addr2_q;

  cim_accum_if #(.xbar_size(4), .output_size(6), .v_cim_tiles(2), .h_cim_tiles(2),
                 .cim_datatype_size(8), .output_datatype_size(10)) b1 ();
  cim_accum_if #(.xbar_size(4), .output_size(6), .v_cim_tiles(2), .h_cim_tiles(2),
                 .cim_datatype_size(8), .output_datatype_size(8)) b2 ();

  cim_accum #(.xbar_size(4), .output_size(6), .v_cim_tiles(2), .h_cim_tiles(2),
              .cim_datatype_size(8), .output_datatype_size(10)) dut1 (
    .clk(clk), .rst(rst), .bus(b1));
  cim_accum #(.xbar_size(4), .output_size(6), .v_cim_tiles(2), .h_cim_tiles(2),
              .cim_datatype_size(8), .output_datatype_size(8)) dut2 (
    .clk(clk), .rst(rst), .bus(b2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Tile output pattern per test mode.
  function automatic logic [7:0] tile_val(input int mode, input int h, input int v, input int c);
    int x;
    case (mode)
      0:       x = c + 1;
      1:       x = h * 16 + c + 1;
      2:       x = -128;
      3:       x = 127;
      4:       x = (v == 0) ? 100 : (-30 - c);
      default: x = (v == 0) ? -100 : 50;
    endcase
    return 8'(x);
  endfunction

  // Tile models: data for the column read in the previous cycle.
  always @(posedge clk) begin
    re1_q = b1.o_cim_re;
    addr1_q = b1.o_cim_addr;
    #1;
    if (re1_q)
      for (int h = 0; h < 2; h++)
        for (int v = 0; v < 2; v++)
          b1.i_cim_data[h*2+v] = tile_val(mode1, h, v, int'(addr1_q));
  end

  always @(posedge clk) begin
    re2_q = b2.o_cim_re;
    addr2_q = b2.o_cim_addr;
    #1;
    if (re2_q)
      for (int h = 0; h < 2; h++)
        for (int v = 0; v < 2; v++)
          b2.i_cim_data[h*2+v] = tile_val(mode2, h, v, int'(addr2_q));
  end

  // Full pass on dut1; reports what was observed, comparisons done by callers.
  task automatic run_pass1(input int mode, input int busy_cycles, input bit done_with_start,
                           input int spur_start_n, output int lat, output int n_start,
                           output int n_re, output bit addr_ok, output bit busy_ok,
                           output bit early_re);
    int exp_addr;
    mode1 = mode;
    lat = -1; n_start = 0; n_re = 0; addr_ok = 1'b1; busy_ok = 1'b1; early_re = 1'b0;
    exp_addr = 0;
    @(posedge clk); #1;
    b1.i_start = 1'b1;
    b1.i_cim_done = done_with_start;
    @(posedge clk); #1;
    b1.i_start = 1'b0;
    b1.i_cim_done = 1'b0;
    for (int g = 0; g < 3; g++) begin
      @(negedge clk);
      if (b1.o_cim_re || !b1.o_busy) early_re = 1'b1;
      @(posedge clk); #1;
    end
    b1.i_cim_done = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      b1.i_cim_done = 1'b0;
      b1.i_start = (n == spur_start_n);
      b1.i_func_busy = (busy_cycles > 0) && (n < 6 + busy_cycles);
      @(negedge clk);
      if (b1.o_start) begin
        n_start++;
        if (lat < 0) lat = n;
      end
      if (b1.o_cim_re) begin
        if (int'(b1.o_cim_addr) != exp_addr) addr_ok = 1'b0;
        exp_addr++;
        n_re++;
      end else if (b1.o_cim_addr != 2'd0) begin
        addr_ok = 1'b0;
      end
      if (lat < 0 && !b1.o_busy) busy_ok = 1'b0;
    end
    @(posedge clk); #1;
    b1.i_start = 1'b0;
    b1.i_func_busy = 1'b0;
    $display("pass dut1 mode=%0d busy=%0d: latency=%0d starts=%0d reads=%0d",
             mode, busy_cycles, lat, n_start, n_re);
  endtask

  // Full pass on dut2 (8-bit results).
  task automatic run_pass2(input int mode, output int lat, output int n_start);
    mode2 = mode;
    lat = -1; n_start = 0;
    @(posedge clk); #1; b2.i_start = 1'b1;
    @(posedge clk); #1; b2.i_start = 1'b0;
    @(posedge clk); #1; b2.i_cim_done = 1'b1;
    for (int n = 1; n <= 15; n++) begin
      @(posedge clk); #1;
      b2.i_cim_done = 1'b0;
      @(negedge clk);
      if (b2.o_start) begin
        n_start++;
        if (lat < 0) lat = n;
      end
    end
    $display("pass dut2 mode=%0d: latency=%0d starts=%0d", mode, lat, n_start);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_cmp++; if (b1.o_busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", b1.o_busy); end
    n_cmp++; if (b1.o_cim_re !== 1'b0) begin n_bad++; $display("FAIL reset_re: got %b want 0", b1.o_cim_re); end
    n_cmp++; if (b1.o_cim_addr !== 2'd0) begin n_bad++; $display("FAIL reset_addr: got %0d want 0", b1.o_cim_addr); end
    n_cmp++; if (b1.o_start !== 1'b0) begin n_bad++; $display("FAIL reset_start: got %b want 0", b1.o_start); end
    n_cmp++; if (b1.o_data !== 60'd0) begin n_bad++; $display("FAIL reset_data1: got %h want 0", b1.o_data); end
    n_cmp++; if (b2.o_data !== 48'd0) begin n_bad++; $display("FAIL reset_data2: got %h want 0", b2.o_data); end
    @(posedge clk); #1;
    rst = 1'b1;
    $display("reset released");
  endtask

  task automatic test_basic();
    int lat, ns, nr;
    bit aok, bok, er;
    int exp_d[6];
    exp_d = '{2, 4, 6, 8, 2, 4};
    run_pass1(0, 0, 1'b0, -1, lat, ns, nr, aok, bok, er);
    n_cmp++; if (lat != 6) begin n_bad++; $display("FAIL basic_latency: got %0d want 6", lat); end
    n_cmp++; if (ns != 1) begin n_bad++; $display("FAIL basic_start_count: got %0d want 1", ns); end
    n_cmp++; if (nr != 4) begin n_bad++; $display("FAIL basic_read_count: got %0d want 4", nr); end
    n_cmp++; if (!aok) begin n_bad++; $display("FAIL basic_addr_seq: got bad sequence want 0..3"); end
    n_cmp++; if (!bok) begin n_bad++; $display("FAIL basic_busy: got drop want held"); end
    n_cmp++; if (er) begin n_bad++; $display("FAIL basic_wait: got early read/idle want wait"); end
    for (int i = 0; i < 6; i++) begin
      n_cmp++;
      if (b1.o_data[i] !== 10'(exp_d[i])) begin
        n_bad++;
        $display("FAIL basic_data[%0d]: got %0d want %0d", i, $signed(b1.o_data[i]), exp_d[i]);
      end
    end
    n_cmp++; if (b1.o_busy !== 1'b0) begin n_bad++; $display("FAIL basic_idle_busy: got %b want 0", b1.o_busy); end
  endtask

  task automatic test_out_of_range();
    int lat, ns, nr;
    bit aok, bok, er;
    int exp_d[6];
    exp_d = '{2, 4, 6, 8, 34, 36};
    run_pass1(1, 0, 1'b0, -1, lat, ns, nr, aok, bok, er);
    n_cmp++; if (lat != 6) begin n_bad++; $display("FAIL oor_latency: got %0d want 6", lat); end
    for (int i = 0; i < 6; i++) begin
      n_cmp++;
      if (b1.o_data[i] !== 10'(exp_d[i])) begin
        n_bad++;
        $display("FAIL oor_data[%0d]: got %0d want %0d", i, $signed(b1.o_data[i]), exp_d[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    int lat, ns, nr;
    bit aok, bok, er;
    run_pass1(0, 5, 1'b0, -1, lat, ns, nr, aok, bok, er);
    n_cmp++; if (lat != 11) begin n_bad++; $display("FAIL bp_latency: got %0d want 11", lat); end
    n_cmp++; if (ns != 1) begin n_bad++; $display("FAIL bp_start_count: got %0d want 1", ns); end
    n_cmp++; if (!bok) begin n_bad++; $display("FAIL bp_busy: got drop want held"); end
    n_cmp++; if (b1.o_data[4] !== 10'd2) begin n_bad++; $display("FAIL bp_data4: got %0d want 2", b1.o_data[4]); end
  endtask

  task automatic test_spurious();
    int lat, ns, nr;
    bit aok, bok, er;
    int exp_d[6];
    exp_d = '{2, 4, 6, 8, 34, 36};
    @(posedge clk); #1; b1.i_cim_done = 1'b1;
    @(posedge clk); #1; b1.i_cim_done = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_cmp++;
      if (b1.o_busy !== 1'b0 || b1.o_cim_re !== 1'b0) begin
        n_bad++;
        $display("FAIL spur_done_idle: got busy=%b re=%b want 0/0", b1.o_busy, b1.o_cim_re);
      end
    end
    run_pass1(1, 0, 1'b1, 2, lat, ns, nr, aok, bok, er);
    n_cmp++; if (er) begin n_bad++; $display("FAIL spur_done_with_start: got early read want wait"); end
    n_cmp++; if (lat != 6) begin n_bad++; $display("FAIL spur_latency: got %0d want 6", lat); end
    n_cmp++; if (ns != 1 || nr != 4 || !aok) begin
      n_bad++; $display("FAIL spur_sequence: got starts=%0d reads=%0d addr_ok=%b want 1/4/1", ns, nr, aok);
    end
    for (int i = 0; i < 6; i++) begin
      n_cmp++;
      if (b1.o_data[i] !== 10'(exp_d[i])) begin
        n_bad++;
        $display("FAIL spur_data[%0d]: got %0d want %0d", i, $signed(b1.o_data[i]), exp_d[i]);
      end
    end
  endtask

  task automatic test_reset_mid_read();
    int lat, ns, nr;
    bit aok, bok, er;
    int n_st;
    mode1 = 0;
    @(posedge clk); #1; b1.i_start = 1'b1;
    @(posedge clk); #1; b1.i_start = 1'b0;
    @(posedge clk); #1; b1.i_cim_done = 1'b1;
    @(posedge clk); #1; b1.i_cim_done = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_cmp++; if (b1.o_cim_addr !== 2'd2 || b1.o_cim_re !== 1'b1) begin
      n_bad++; $display("FAIL rmr_at_col2: got addr=%0d re=%b want 2/1", b1.o_cim_addr, b1.o_cim_re);
    end
    rst = 1'b0;
    #1;
    n_cmp++; if (b1.o_busy !== 1'b0) begin n_bad++; $display("FAIL rmr_busy: got %b want 0", b1.o_busy); end
    n_cmp++; if (b1.o_cim_re !== 1'b0) begin n_bad++; $display("FAIL rmr_re: got %b want 0", b1.o_cim_re); end
    n_cmp++; if (b1.o_data !== 60'd0) begin n_bad++; $display("FAIL rmr_data: got %h want 0", b1.o_data); end
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    b1.i_start = 1'b1;
    @(posedge clk); #1;
    b1.i_start = 1'b0;
    n_st = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (b1.o_start) n_st++;
      n_cmp++;
      if (b1.o_busy !== 1'b1 || b1.o_cim_re !== 1'b0) begin
        n_bad++; $display("FAIL rmr_after_release[%0d]: got busy=%b re=%b want 1/0", k, b1.o_busy, b1.o_cim_re);
      end
    end
    n_cmp++; if (n_st != 0) begin n_bad++; $display("FAIL rmr_no_start: got %0d want 0", n_st); end
    run_pass1(0, 0, 1'b0, -1, lat, ns, nr, aok, bok, er);
    n_cmp++; if (lat != 6 || ns != 1) begin n_bad++; $display("FAIL rmr_next_pass: got lat=%0d starts=%0d want 6/1", lat, ns); end
    n_cmp++; if (b1.o_data[3] !== 10'd8 || b1.o_data[5] !== 10'd4) begin
      n_bad++; $display("FAIL rmr_next_data: got %0d/%0d want 8/4", b1.o_data[3], b1.o_data[5]);
    end
  endtask

  task automatic test_saturation();
    int lat, ns;
    run_pass2(2, lat, ns);
    n_cmp++; if (lat != 6 || ns != 1) begin n_bad++; $display("FAIL sat_neg_pass: got lat=%0d starts=%0d want 6/1", lat, ns); end
    for (int i = 0; i < 6; i++) begin
      n_cmp++;
      if (b2.o_data[i] !== 8'h80) begin n_bad++; $display("FAIL sat_neg[%0d]: got %0d want -128", i, $signed(b2.o_data[i])); end
    end
    run_pass2(3, lat, ns);
    for (int i = 0; i < 6; i++) begin
      n_cmp++;
      if (b2.o_data[i] !== 8'h7f) begin n_bad++; $display("FAIL sat_pos[%0d]: got %0d want 127", i, $signed(b2.o_data[i])); end
    end
  endtask

  task automatic test_sum_signs();
    int lat, ns;
    int exp_d[6];
    exp_d = '{70, 69, 68, 67, 70, 69};
    run_pass2(4, lat, ns);
    for (int i = 0; i < 6; i++) begin
      n_cmp++;
      if (b2.o_data[i] !== 8'(exp_d[i])) begin
        n_bad++; $display("FAIL mixed[%0d]: got %0d want %0d", i, $signed(b2.o_data[i]), exp_d[i]);
      end
    end
    run_pass2(5, lat, ns);
    for (int i = 0; i < 6; i++) begin
      n_cmp++;
      if (b2.o_data[i] !== 8'hce) begin n_bad++; $display("FAIL neg_sum[%0d]: got %0d want -50", i, $signed(b2.o_data[i])); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0;
    b1.i_start = 1'b0; b1.i_cim_done = 1'b0; b1.i_func_busy = 1'b0;
    b2.i_start = 1'b0; b2.i_cim_done = 1'b0; b2.i_func_busy = 1'b0;
    test_reset();
    test_basic();
    test_out_of_range();
    test_backpressure();
    test_spurious();
    test_reset_mid_read();
    test_saturation();
    test_sum_signs();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
